counter_2b_buttons: RTL and testbench
=====================================

# counter_2b_buttons

- Upstream stage of the 2-bit seven-segment decoder.
- Turns two raw push-buttons (up, down) into a debounced, wrap-around 2-bit value 0..3 and drives it onto the decoder's `bin` input.
- Contains per-button synchronizers, per-button debounce state machines and the value register.
- Everything is in one clock domain; the only asynchronous inputs are the buttons.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable cycles needed to accept a press or a release (10 ms at 50 MHz). Legal range is ≥ 2.
- `BTN_ACTIVE_LOW`, default 1: 1 means a raw button reads 0 when pressed.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `btn_up`  input  1  raw up button, asynchronous to `clk`.
- `btn_down`  input  1  raw down button, asynchronous to `clk`.
- `clear`  input  1  synchronous clear of the value, active-high, already in the `clk` domain.
- `bin`  output  2  current value; connects directly to the decoder.
- `step`  output  1  one-cycle pulse, high in the cycle immediately after `bin` changed because of a button.

## Operation

- **Polarity:** each raw button is first normalized to "pressed = 1" according to `BTN_ACTIVE_LOW`.
- **Synchronizer:** each normalized button passes through a 2-flop synchronizer. Reset loads the released level (0).
- **Debounce FSM (one per button):** the counter is `$clog2(DEBOUNCE_CYCLES)` bits wide.
  - IDLE: when the synced level is pressed, go to ARM with cnt=1.
  - ARM: while pressed, cnt increments. If released, return to IDLE with no pulse. When cnt == DEBOUNCE_CYCLES-1 and still pressed, go to HELD and raise that button's press pulse for exactly one cycle.
  - HELD: when released, go to REL_ARM with cnt=1. Holding the button produces no further pulses (no auto-repeat).
  - REL_ARM: while released, cnt increments. If pressed again, return to HELD with no pulse. When cnt == DEBOUNCE_CYCLES-1 and still released, go to IDLE.
- **Value update,** evaluated at each edge in priority order:
  1. `clear` set: `bin` becomes 0 and `step` stays 0. Any press pulse in that cycle is discarded. The FSMs are not affected by `clear`.
  2. Up pulse only: `bin` becomes `bin`+1 modulo 4 (3 wraps to 0).
  3. Down pulse only: `bin` becomes `bin`-1 modulo 4 (0 wraps to 3).
  4. Both pulses in the same cycle: no change and no `step`.
- **Outputs:** `bin` and `step` are both registered with no combinational path from the inputs. `step` is 1 for exactly one cycle on each accepted increment or decrement.
- **Reset:** asserting `rst` at any time immediately forces `bin`=0, `step`=0, both FSMs to IDLE, counters to 0 and synchronizers to released. This applies mid-debounce as well, so a press in progress is lost. After deassertion, a button that is still held counts as a new press starting from IDLE.

## Timing

- Reset values: `bin`=2'b00, `step`=0.
- **Press latency:** suppose the normalized button goes pressed before edge k and stays pressed. Then `bin` changes at edge k+2+DEBOUNCE_CYCLES, and `step` is high from that edge until the next one.
- **Short glitches:** a press shorter than DEBOUNCE_CYCLES synced cycles produces no change.
- **Release:** after an accepted press, the button must be released for DEBOUNCE_CYCLES synced cycles before another press can be accepted. Bounces during release are absorbed.
- **Throughput:** at most one accepted step per button every 2×DEBOUNCE_CYCLES cycles.
- `clear` takes effect at the next edge and has a latency of one cycle.

## Test plan

All scenarios run with DEBOUNCE_CYCLES=4 and BTN_ACTIVE_LOW=1.

1. **Reset:** assert `rst` mid-simulation without a clock edge. Required: `bin`=0 and `step`=0 immediately. After release with no button activity, `bin` stays 0 for 100 cycles.
2. **Clean up presses and wrap:**
   - Stimulus: press `btn_up` (drive 0) for 10 cycles, release for 10 cycles, and repeat 5 times.
   - Required `bin` sequence: 1, 2, 3, 0, 1.
   - Each change lands exactly 6 edges after the press, with exactly one `step` pulse per press.
3. **Down wrap and bounce rejection:**
   - Stimulus: from `bin`=0, `btn_down` toggles every cycle for 8 cycles, then is held for 10 cycles, then bounces on release.
   - Required: `bin`=3, with exactly one `step` pulse over the whole sequence.
4. **Glitch and hold:**
   - A 3-cycle press of `btn_up`: required no change.
   - A 200-cycle hold of `btn_up`: required exactly one increment (no auto-repeat).
5. **Simultaneous and clear:**
   - Press both buttons on the same cycle with `bin`=2: required `bin` stays 2 and `step` stays 0.
   - Assert `clear` in the same cycle as an accepted up pulse: required `bin`=0 and `step`=0.
6. **Reset mid-debounce:** assert `rst` when `btn_up` has been held for 2 of its 4 debounce cycles, keep holding, and deassert `rst`. Required: the increment occurs a full 2+4 edges after the `rst` deassertion, not earlier.

Source files
------------

// File: rtl/counter_2b_buttons.sv
// Two raw push-buttons (up/down) -> synchronized, debounced press pulses -> wrap-around
// 2-bit value feeding the seven-segment decoder, with a one-cycle step strobe.
module counter_2b_buttons #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       clear,
  output logic [1:0] bin,
  output logic       step
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    HELD    = 2'd2,
    REL_ARM = 2'd3
  } state_t;

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]       btn_n;
  logic [1:0]       sync1_q, sync2_q;
  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       press_q, press_d;
  logic [1:0]       bin_q, bin_d;
  logic             step_q, step_d;

  assign btn_n = BTN_ACTIVE_LOW ? ~{btn_down, btn_up} : {btn_down, btn_up};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      press_d[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = ARM;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ARM: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            state_d[i] = REL_ARM;
            cnt_d[i]   = CNT_ONE;
          end
        end
        REL_ARM: begin
          // A re-press while the release is still settling is treated as bounce.
          if (sync2_q[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Clear outranks the buttons; simultaneous up and down cancel out.
  always_comb begin
    bin_d  = bin_q;
    step_d = 1'b0;
    if (clear) begin
      bin_d = 2'd0;
    end else if (press_q == 2'b01) begin
      bin_d  = bin_q + 2'd1;
      step_d = 1'b1;
    end else if (press_q == 2'b10) begin
      bin_d  = bin_q - 2'd1;
      step_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      press_q <= 2'b00;
      bin_q   <= 2'd0;
      step_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      press_q <= press_d;
      bin_q   <= bin_d;
      step_q  <= step_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bin  = bin_q;
  assign step = step_q;

endmodule

// File: tb/tb_counter_2b_buttons.sv
// Bench for counter_2b_buttons: directed scenarios plus random button activity, checked
// against a run-length debounce model and fixed expected values.
module tb_counter_2b_buttons;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b1;
  logic       btn_down = 1'b1;
  logic       clear = 1'b0;
  logic [1:0] bin;
  logic       step;

  int checks = 0;
  int errors = 0;
  int steps_seen = 0;

  // Model state: value, strobe, two-edge input history, accepted level, run length
  // of disagreeing samples, and press pulses waiting to be applied.
  logic [1:0] m_bin;
  logic       m_step;
  logic [1:0] m_h1, m_h2;
  logic [1:0] m_acc;
  logic [1:0] m_pend;
  int         m_run [2];

  counter_2b_buttons #(.DEBOUNCE_CYCLES(DC), .BTN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .clear(clear), .bin(bin), .step(step)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_bin = 2'd0; m_step = 1'b0; m_h1 = 2'b00; m_h2 = 2'b00;
    m_acc = 2'b00; m_pend = 2'b00; m_run[0] = 0; m_run[1] = 0;
  endtask

  task automatic model_edge();
    logic [1:0] fresh;
    if (rst) begin
      model_reset();
      return;
    end
    m_step = 1'b0;
    if (clear) m_bin = 2'd0;
    else if (m_pend == 2'b01) begin m_bin = m_bin + 2'd1; m_step = 1'b1; end
    else if (m_pend == 2'b10) begin m_bin = m_bin - 2'd1; m_step = 1'b1; end
    fresh = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (m_h2[i] != m_acc[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_acc[i] = m_h2[i];
          m_run[i] = 0;
          fresh[i] = m_h2[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pend = fresh;
    m_h2 = m_h1;
    m_h1 = {~btn_down, ~btn_up};
  endtask

  // Drive one cycle of stimulus (1 = pressed) and return at the following negedge.
  task automatic tick(input logic up_p, input logic dn_p, input logic clr);
    btn_up = ~up_p; btn_down = ~dn_p; clear = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (step === 1'b1) steps_seen++;
  endtask

  task automatic test_reset();
    rst = 1'b1; model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bin !== 2'd0 || step !== 1'b0) begin
      errors++; $display("FAIL reset_state bin=%0d step=%0b required bin=0 step=0", bin, step);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(c < 10, 1'b0, 1'b0);
      checks++;
      if (bin !== m_bin || step !== m_step) begin
        errors++; $display("FAIL reset_model bin=%0d step=%0b required bin=%0d step=%0b", bin, step, m_bin, m_step);
      end
    end
    checks++;
    if (bin !== 2'd1) begin
      errors++; $display("FAIL reset_pre_press bin=%0d required 1", bin);
    end
    #2 rst = 1'b1; model_reset();
    #1 checks++;
    if (bin !== 2'd0 || step !== 1'b0) begin
      errors++; $display("FAIL reset_async bin=%0d step=%0b required bin=0 step=0", bin, step);
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (bin !== 2'd0 || step !== 1'b0) begin
        errors++; $display("FAIL reset_idle cycle=%0d bin=%0d step=%0b required 0/0", c, bin, step);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [1:0] exp_seq [5];
    logic [1:0] prev;
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    prev = 2'd0;
    for (int p = 0; p < 5; p++) begin
      steps_seen = 0;
      for (int c = 1; c <= 20; c++) begin
        tick(c <= 10, 1'b0, 1'b0);
        checks++;
        if (bin !== m_bin || step !== m_step) begin
          errors++; $display("FAIL up_model p=%0d c=%0d bin=%0d step=%0b required bin=%0d step=%0b", p, c, bin, step, m_bin, m_step);
        end
        if (c == 6) begin
          checks++;
          if (bin !== prev) begin
            errors++; $display("FAIL up_early p=%0d bin=%0d required %0d", p, bin, prev);
          end
        end
        if (c == 7) begin
          checks++;
          if (bin !== exp_seq[p] || step !== 1'b1) begin
            errors++; $display("FAIL up_latency p=%0d bin=%0d step=%0b required bin=%0d step=1", p, bin, step, exp_seq[p]);
          end
        end
      end
      checks++;
      if (steps_seen != 1) begin
        errors++; $display("FAIL up_steps p=%0d steps=%0d required 1", p, steps_seen);
      end
      prev = exp_seq[p];
    end
  endtask

  task automatic test_down_bounce();
    tick(1'b0, 1'b0, 1'b1);
    checks++;
    if (bin !== 2'd0 || step !== 1'b0) begin
      errors++; $display("FAIL down_clear bin=%0d step=%0b required 0/0", bin, step);
    end
    steps_seen = 0;
    for (int c = 0; c < 34; c++) begin
      if (c < 8)       tick(1'b0, (c % 2) == 0, 1'b0);
      else if (c < 18) tick(1'b0, 1'b1, 1'b0);
      else if (c < 24) tick(1'b0, (c % 2) == 1, 1'b0);
      else             tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (bin !== m_bin || step !== m_step) begin
        errors++; $display("FAIL down_model c=%0d bin=%0d step=%0b required bin=%0d step=%0b", c, bin, step, m_bin, m_step);
      end
    end
    checks++;
    if (bin !== 2'd3 || steps_seen != 1) begin
      errors++; $display("FAIL down_wrap bin=%0d steps=%0d required bin=3 steps=1", bin, steps_seen);
    end
  endtask

  task automatic test_glitch_hold();
    steps_seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick(c < 3, 1'b0, 1'b0);
      checks++;
      if (bin !== 2'd3 || step !== 1'b0) begin
        errors++; $display("FAIL glitch c=%0d bin=%0d step=%0b required bin=3 step=0", c, bin, step);
      end
    end
    for (int c = 0; c < 210; c++) begin
      tick(c < 200, 1'b0, 1'b0);
      checks++;
      if (bin !== m_bin || step !== m_step) begin
        errors++; $display("FAIL hold_model c=%0d bin=%0d step=%0b required bin=%0d step=%0b", c, bin, step, m_bin, m_step);
      end
    end
    checks++;
    if (bin !== 2'd0 || steps_seen != 1) begin
      errors++; $display("FAIL hold_repeat bin=%0d steps=%0d required bin=0 steps=1", bin, steps_seen);
    end
  endtask

  task automatic test_simul_clear();
    for (int c = 0; c < 40; c++) tick((c % 20) < 10, 1'b0, 1'b0);
    checks++;
    if (bin !== 2'd2) begin
      errors++; $display("FAIL simul_setup bin=%0d required 2", bin);
    end
    steps_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick(c < 10, c < 10, 1'b0);
      checks++;
      if (bin !== 2'd2 || step !== 1'b0) begin
        errors++; $display("FAIL simul c=%0d bin=%0d step=%0b required bin=2 step=0", c, bin, step);
      end
    end
    for (int c = 1; c <= 20; c++) begin
      tick(c <= 10, 1'b0, c == 7);
      checks++;
      if (bin !== m_bin || step !== m_step) begin
        errors++; $display("FAIL clear_model c=%0d bin=%0d step=%0b required bin=%0d step=%0b", c, bin, step, m_bin, m_step);
      end
      if (c == 7) begin
        checks++;
        if (bin !== 2'd0 || step !== 1'b0) begin
          errors++; $display("FAIL clear_vs_pulse bin=%0d step=%0b required bin=0 step=0", bin, step);
        end
      end
    end
    checks++;
    if (bin !== 2'd0 || steps_seen != 0) begin
      errors++; $display("FAIL clear_after bin=%0d steps=%0d required bin=0 steps=0", bin, steps_seen);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) tick(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1; model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick(c <= 10, 1'b0, 1'b0);
      checks++;
      if (bin !== m_bin || step !== m_step) begin
        errors++; $display("FAIL rstmid_model c=%0d bin=%0d step=%0b required bin=%0d step=%0b", c, bin, step, m_bin, m_step);
      end
      if (c == 6) begin
        checks++;
        if (bin !== 2'd0) begin
          errors++; $display("FAIL rstmid_early bin=%0d required 0", bin);
        end
      end
      if (c == 7) begin
        checks++;
        if (bin !== 2'd1 || step !== 1'b1) begin
          errors++; $display("FAIL rstmid_latency bin=%0d step=%0b required bin=1 step=1", bin, step);
        end
      end
    end
  endtask

  task automatic test_random();
    logic up_l, dn_l;
    int   up_len, dn_len;
    up_l = 1'b0; dn_l = 1'b0; up_len = 0; dn_len = 0;
    for (int c = 0; c < 2000; c++) begin
      if (up_len == 0) begin up_l = $urandom_range(1, 0) == 1; up_len = $urandom_range(12, 1); end
      if (dn_len == 0) begin dn_l = $urandom_range(1, 0) == 1; dn_len = $urandom_range(12, 1); end
      up_len--; dn_len--;
      tick(up_l, dn_l, $urandom_range(39, 0) == 0);
      checks++;
      if (bin !== m_bin || step !== m_step) begin
        errors++; $display("FAIL random c=%0d bin=%0d step=%0b required bin=%0d step=%0b", c, bin, step, m_bin, m_step);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_wrap();
    test_down_bounce();
    test_glitch_hold();
    test_simul_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
